// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver producing a byte plus a one-cycle strobe; even parity via UART_RX_PARITY_EN
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BAUD_CNT_MAX);
  localparam logic [CW-1:0] WRAP = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] MID = CW'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP = 3'd4;
  logic          rx_s1, rx_s2, rx_s3;
  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          fall, wrap, mid, pbad;
  assign fall = rx_s3 & ~rx_s2;
  assign wrap = baud_cnt == WRAP;
  assign mid = baud_cnt == MID;
`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  assign pbad = ^{shift_reg, parity_bit};
`else
  assign pbad = 1'b0;
  assign parity_err = 1'b0;
`endif
  // synchronize the async line; reset to idle-high so no false edge after reset
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) {rx_s3, rx_s2, rx_s1} <= 3'b111;
    else {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
  // frame FSM: bit timing, mid-bit sampling, result strobes
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      po_data <= '0;
      po_flag <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      po_flag <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      baud_cnt <= (state == IDLE || wrap) ? '0 : baud_cnt + CW'(1);
      case (state)
        IDLE: if (fall) state <= START;
        START:
          if (mid && rx_s2) state <= IDLE;
          else if (wrap) begin
            state <= DATA;
            bit_cnt <= '0;
          end
        DATA: begin
          if (mid) shift_reg[bit_cnt] <= rx_s2;
          if (wrap) begin
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == 3'd7) state <= PARITY;
`else
            if (bit_cnt == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid) parity_bit <= rx_s2;
          if (wrap) state <= STOP;
        end
`endif
        STOP:
          if (mid) begin
            state <= IDLE;
            frame_err <= ~rx_s2;
            po_flag <= rx_s2 & ~pbad;
            if (rx_s2 & ~pbad) po_data <= shift_reg;
`ifdef UART_RX_PARITY_EN
            parity_err <= pbad;
`endif
          end
        default: state <= IDLE;
      endcase
    end
endmodule
